// File: rtl/tta_move_issuer.sv
// Move issuer for the guarded 1W/1R boolean RF socket: buffers move words,
// reads register sources, evaluates the guard and drives or squashes the write.
module tta_move_issuer #(
  parameter int DATA_W = 1,
  parameter int ADDR_W = 1,
  parameter int DEPTH  = 4,
  parameter int MOVE_W = 3 + 3*ADDR_W + DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_glock,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [MOVE_W-1:0]      io_in_bits,
  output logic                   io_r1load,
  output logic [ADDR_W-1:0]      io_r1opcode,
  input  logic [DATA_W-1:0]      io_r1data,
  input  logic [(1<<ADDR_W)-1:0] io_guard,
  output logic                   io_t1load,
  output logic [ADDR_W-1:0]      io_t1opcode,
  output logic [DATA_W-1:0]      io_t1data,
  output logic                   io_busy,
  output logic [7:0]             io_squash_cnt
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [MOVE_W-1:0] r_mem [DEPTH];
  logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
  logic              r_w_valid, r_w_pass;
  logic [ADDR_W-1:0] r_w_dst;
  logic [DATA_W-1:0] r_w_operand;
  logic [7:0]        r_squash_cnt;

  logic              w_full, w_empty, w_push, w_fire, w_fwd, w_pass;
  logic [MOVE_W-1:0] w_head;
  logic              w_g_en, w_g_inv, w_src_rf;
  logic [ADDR_W-1:0] w_g_sel, w_src_addr, w_dst;
  logic [DATA_W-1:0] w_imm, w_operand;

  // Extra pointer MSB distinguishes full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = io_in_valid & ~w_full;
  assign w_fire  = ~w_empty & ~io_glock;
  assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

  assign w_g_en     = w_head[0];
  assign w_g_inv    = w_head[1];
  assign w_g_sel    = w_head[2 +: ADDR_W];
  assign w_src_rf   = w_head[2 + ADDR_W];
  assign w_src_addr = w_head[3 + ADDR_W +: ADDR_W];
  assign w_imm      = w_head[3 + 2*ADDR_W +: DATA_W];
  assign w_dst      = w_head[3 + 2*ADDR_W + DATA_W +: ADDR_W];

  // RF read port does not see the current write, so forward it here.
  assign w_fwd     = w_src_rf & io_t1load & (io_t1opcode == w_src_addr);
  assign w_operand = !w_src_rf ? w_imm : (w_fwd ? io_t1data : io_r1data);
  assign w_pass    = ~w_g_en | (io_guard[w_g_sel] ^ w_g_inv);

  assign io_in_ready   = ~w_full;
  assign io_r1load     = w_fire & w_src_rf;
  assign io_r1opcode   = w_fire ? w_src_addr : '0;
  assign io_t1load     = r_w_valid & r_w_pass & ~io_glock;
  assign io_t1opcode   = r_w_dst;
  assign io_t1data     = r_w_operand;
  assign io_busy       = ~w_empty | r_w_valid;
  assign io_squash_cnt = r_squash_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= io_in_bits;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_w_valid    <= 1'b0;
      r_w_pass     <= 1'b0;
      r_w_dst      <= '0;
      r_w_operand  <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_fire) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      if (!io_glock) begin
        r_w_valid <= w_fire;
        if (w_fire) begin
          r_w_pass    <= w_pass;
          r_w_dst     <= w_dst;
          r_w_operand <= w_operand;
        end
        if (r_w_valid && !r_w_pass && r_squash_cnt != 8'hFF)
          r_squash_cnt <= r_squash_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_tta_move_issuer.sv
// Directed bench for tta_move_issuer: per-cycle vector table plus reset and
// squash-saturation sequences, with a small external RF model.
module tb_tta_move_issuer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_glock = 1'b0;
  logic       io_in_valid = 1'b0;
  logic [6:0] io_in_bits = '0;
  logic       io_in_ready, io_r1load, io_t1load, io_busy;
  logic [0:0] io_r1opcode, io_t1opcode, io_r1data, io_t1data;
  logic [1:0] io_guard;
  logic [7:0] io_squash_cnt;
  logic [1:0] rf_q;

  int n_chk = 0;
  int n_fail = 0;

  tta_move_issuer dut (
    .clk(clk), .reset(reset), .io_glock(io_glock),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
    .io_r1load(io_r1load), .io_r1opcode(io_r1opcode), .io_r1data(io_r1data),
    .io_guard(io_guard), .io_t1load(io_t1load), .io_t1opcode(io_t1opcode),
    .io_t1data(io_t1data), .io_busy(io_busy), .io_squash_cnt(io_squash_cnt)
  );

  always #5 clk = ~clk;

  // External RF: read port sees only committed state, guard vector sees the current write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rf_q <= '0;
    else if (io_t1load) rf_q[io_t1opcode] <= io_t1data;
  end
  always_comb begin
    io_guard = rf_q;
    if (io_t1load) io_guard[io_t1opcode] = io_t1data;
  end
  assign io_r1data = rf_q[io_r1opcode];

  typedef struct {
    logic       glock, vld;
    logic [6:0] bits;
    logic       rdy, r1l, r1op, t1l, t1op, t1d, busy;
    logic [7:0] sq;
  } vec_t;

  vec_t vt [35];

  function automatic logic [6:0] mv(input logic gen, ginv, gsel, srf, saddr, imm, dst);
    return {dst, imm, saddr, srf, gsel, ginv, gen};
  endfunction

  function automatic vec_t v(input logic gl, vl, input logic [6:0] b,
                             input logic rdy, r1l, r1op, t1l, t1op, t1d, busy,
                             input logic [7:0] sq);
    vec_t r;
    r.glock = gl; r.vld = vl; r.bits = b; r.rdy = rdy; r.r1l = r1l; r.r1op = r1op;
    r.t1l = t1l; r.t1op = t1op; r.t1d = t1d; r.busy = busy; r.sq = sq;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, 8'(io_in_ready), 8'd1);
    chk({tag, " r1load"}, 8'(io_r1load), 8'd0);
    chk({tag, " r1opcode"}, 8'(io_r1opcode), 8'd0);
    chk({tag, " t1load"}, 8'(io_t1load), 8'd0);
    chk({tag, " t1opcode"}, 8'(io_t1opcode), 8'd0);
    chk({tag, " t1data"}, 8'(io_t1data), 8'd0);
    chk({tag, " busy"}, 8'(io_busy), 8'd0);
    chk({tag, " squash_cnt"}, io_squash_cnt, 8'd0);
  endtask

  task automatic drive(input logic gl, input logic vl, input logic [6:0] b);
    @(negedge clk);
    io_glock = gl; io_in_valid = vl; io_in_bits = b;
    #1;
  endtask

  initial begin
    logic [6:0] mA, mB, mC, mD, mF, mG, mH, mI, mK0, mK2, mK3, mSQ, z;
    logic t1_seen;
    string s;
    z   = '0;
    mA  = mv(0,0,0,0,0,1,1);  // imm 1 -> r1
    mB  = mv(0,0,0,0,0,1,0);  // imm 1 -> r0
    mC  = mv(0,0,0,1,0,0,1);  // r0 -> r1
    mD  = mv(0,0,0,0,0,0,1);  // imm 0 -> r1
    mF  = mv(1,0,1,0,0,0,0);  // if r1: imm 0 -> r0
    mG  = mv(1,1,1,0,0,1,0);  // if !r1: imm 1 -> r0
    mH  = mv(0,0,0,0,0,0,0);  // imm 0 -> r0
    mI  = mv(0,0,0,1,1,0,1);  // r1 -> r1
    mK0 = mH; mK2 = mB; mK3 = mD;
    mSQ = mv(1,0,0,0,0,1,1);  // if r0 (r0 = 0): imm 1 -> r1

    //            gl vl bits | rdy r1l r1op t1l t1op t1d busy sq
    vt[0]  = v(0, 1, mA,  1, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = v(0, 0, z,   1, 0, 0, 0, 0, 0, 1, 0);
    vt[2]  = v(0, 0, z,   1, 0, 0, 1, 1, 1, 1, 0);
    vt[3]  = v(0, 0, z,   1, 0, 0, 0, 1, 1, 0, 0);
    vt[4]  = v(0, 1, mB,  1, 0, 0, 0, 1, 1, 0, 0);
    vt[5]  = v(0, 1, mC,  1, 0, 0, 0, 1, 1, 1, 0);
    vt[6]  = v(0, 0, z,   1, 1, 0, 1, 0, 1, 1, 0);
    vt[7]  = v(0, 0, z,   1, 0, 0, 1, 1, 1, 1, 0);
    vt[8]  = v(0, 1, mD,  1, 0, 0, 0, 1, 1, 0, 0);
    vt[9]  = v(0, 1, mA,  1, 0, 0, 0, 1, 1, 1, 0);
    vt[10] = v(0, 1, mF,  1, 0, 0, 1, 1, 0, 1, 0);
    vt[11] = v(0, 1, mG,  1, 0, 0, 1, 1, 1, 1, 0);
    vt[12] = v(0, 0, z,   1, 0, 0, 1, 0, 0, 1, 0);
    vt[13] = v(0, 0, z,   1, 0, 0, 0, 0, 1, 1, 0);
    vt[14] = v(0, 0, z,   1, 0, 0, 0, 0, 1, 0, 1);
    vt[15] = v(0, 1, mH,  1, 0, 0, 0, 0, 1, 0, 1);
    vt[16] = v(0, 1, mI,  1, 0, 0, 0, 0, 1, 1, 1);
    vt[17] = v(1, 1, mA,  1, 0, 0, 0, 0, 0, 1, 1);
    vt[18] = v(1, 0, z,   1, 0, 0, 0, 0, 0, 1, 1);
    vt[19] = v(1, 0, z,   1, 0, 0, 0, 0, 0, 1, 1);
    vt[20] = v(0, 0, z,   1, 1, 1, 1, 0, 0, 1, 1);
    vt[21] = v(0, 0, z,   1, 0, 0, 1, 1, 1, 1, 1);
    vt[22] = v(0, 0, z,   1, 0, 0, 1, 1, 1, 1, 1);
    vt[23] = v(0, 0, z,   1, 0, 0, 0, 1, 1, 0, 1);
    vt[24] = v(1, 1, mK0, 1, 0, 0, 0, 1, 1, 0, 1);
    vt[25] = v(1, 1, mA,  1, 0, 0, 0, 1, 1, 1, 1);
    vt[26] = v(1, 1, mK2, 1, 0, 0, 0, 1, 1, 1, 1);
    vt[27] = v(1, 1, mK3, 1, 0, 0, 0, 1, 1, 1, 1);
    vt[28] = v(1, 1, mB,  0, 0, 0, 0, 1, 1, 1, 1);
    vt[29] = v(0, 1, mB,  0, 0, 0, 0, 1, 1, 1, 1);
    vt[30] = v(0, 0, z,   1, 0, 0, 1, 0, 0, 1, 1);
    vt[31] = v(0, 0, z,   1, 0, 0, 1, 1, 1, 1, 1);
    vt[32] = v(0, 0, z,   1, 0, 0, 1, 0, 1, 1, 1);
    vt[33] = v(0, 0, z,   1, 0, 0, 1, 1, 0, 1, 1);
    vt[34] = v(0, 0, z,   1, 0, 0, 0, 1, 0, 0, 1);

    repeat (2) @(negedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 35; i++) begin
      drive(vt[i].glock, vt[i].vld, vt[i].bits);
      s = $sformatf("c%0d", i);
      chk({s, " in_ready"}, 8'(io_in_ready), 8'(vt[i].rdy));
      chk({s, " r1load"}, 8'(io_r1load), 8'(vt[i].r1l));
      chk({s, " r1opcode"}, 8'(io_r1opcode), 8'(vt[i].r1op));
      chk({s, " t1load"}, 8'(io_t1load), 8'(vt[i].t1l));
      chk({s, " t1opcode"}, 8'(io_t1opcode), 8'(vt[i].t1op));
      chk({s, " t1data"}, 8'(io_t1data), 8'(vt[i].t1d));
      chk({s, " busy"}, 8'(io_busy), 8'(vt[i].busy));
      chk({s, " squash_cnt"}, io_squash_cnt, vt[i].sq);
    end

    // Reset with W holding a valid move and three moves queued behind glock.
    drive(0, 1, mA);
    drive(0, 1, mA);
    drive(1, 1, mA);
    drive(1, 1, mA);
    drive(1, 0, z);
    chk("prereset t1opcode", 8'(io_t1opcode), 8'd1);
    chk("prereset busy", 8'(io_busy), 8'd1);
    chk("prereset t1load", 8'(io_t1load), 8'd0);
    @(negedge clk);
    reset = 1'b1; io_glock = 1'b0; io_in_valid = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b0;
    t1_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, z);
      if (io_t1load || io_busy) t1_seen = 1'b1;
    end
    chk("postreset no write", 8'(t1_seen), 8'd0);

    // 256 guard-failing moves back to back.
    t1_seen = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, mSQ);
      if (io_t1load || !io_in_ready) t1_seen = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, z);
      if (io_t1load) t1_seen = 1'b1;
    end
    chk("squash no write", 8'(t1_seen), 8'd0);
    chk("squash saturate", io_squash_cnt, 8'd255);
    chk("squash idle busy", 8'(io_busy), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
